out_drain: RTL
==============

# out_drain

Result-bank reader for the matrix multiplier's output path. It consumes the output-latch write interface driven by the output control sequencer: `out_gate`, the 4-bit `ouputcon` store code and the end-of-frame `out_sclr` strobe. It captures the ten upper-triangular results b11..b44 from the result bus into a capture bank. At end of frame it hands the bank to a drain bank and streams the ten words out, in code order, over a valid/ready port, so the next frame can be captured while the current one drains.

## Interface
Parameters:
- `DW`, default 16: result word width.
- `NRES`, default 10: results per frame. This value is fixed by the store-code map and must not be overridden.

Ports (name, direction, width, meaning):
- `CLK`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `out_gate`  in  1  output-latch enable from the sequencer.
- `ouputcon`  in  4  store code. 1..10 select slots b11,b12,b13,b14,b22,b23,b24,b33,b34,b44. 0 means no store.
- `out_sclr`  in  1  end-of-frame strobe, high for exactly one cycle.
- `res_in`  in  DW  result bus, sampled together with a store code.
- `rd_data`  out  DW  drained word.
- `rd_idx`  out  4  store code (1..10) of the word on `rd_data`.
- `rd_valid`  out  1  `rd_data` is valid.
- `rd_ready`  in  1  downstream accepts the word.
- `rd_last`  out  1  high with the word where `rd_idx`==10.
- `busy`  out  1  drain bank is occupied.
- `frame_err`  out  1  one-cycle pulse: a frame was transferred with at least one slot not written.

## Operation
- Capture: a store happens in any cycle with `out_gate`=1 and `ouputcon` in 1..10.
  - `res_in` is written to capture slot `ouputcon`-1 and the slot's valid bit is set.
  - A repeated code overwrites the slot (last write wins).
  - Codes 0 and 11..15 are ignored.
- Transfer: on `out_sclr`=1, the capture bank and its valid mask are copied to the drain bank, then the capture bank's valid mask is cleared.
  - A store in the same cycle as `out_sclr` is included in the transferred frame, via a bypass into the drain bank.
  - Unwritten slots transfer as 0, and `frame_err` pulses on the next cycle.
- Drain FSM states are IDLE and SEND.
  - IDLE → SEND on a transfer. The index is set to 1.
  - In SEND, `rd_valid`=1, `rd_data` = drain[idx], `rd_idx` = idx, `rd_last` = (idx==10).
  - On a handshake (`rd_valid` and `rd_ready` both high): if idx==10, go to IDLE; otherwise increment idx.
  - `busy` = (state==SEND).
- `rd_data` and `rd_idx` hold stable while `rd_valid`=1 and `rd_ready`=0.
- Overrun: `out_sclr` while in SEND, without the final handshake in the same cycle.
  - The new frame is dropped and its capture mask is cleared.
  - The drain in progress is unaffected.
- Simultaneous events:
  - Final handshake (idx==10) in the same cycle as `out_sclr`: the transfer is accepted and SEND restarts at idx 1 on the next cycle, with no idle bubble.
  - `out_sclr` in the same cycle as a capture store: the store is folded in, as described under Transfer.
- Reset (`reset_n`=0, at any time, including mid-drain) forces:
  - state IDLE, idx 1, both banks and masks 0;
  - `rd_valid`=0, `rd_last`=0, `busy`=0, `frame_err`=0, `rd_data`=0, `rd_idx`=0.

## Timing
- Stores take effect on the rising edge where they are sampled.
- `out_sclr` sampled at edge N gives `rd_valid`=1 from cycle N+1.
- With `rd_ready` held high, one word is drained per cycle: ten cycles, last word in cycle N+10, `busy` low at N+11.
- `frame_err` is registered and is high for the single cycle N+1.
- The sequencer frame period is 29 cycles. At full `rd_ready`, a drain never overlaps the next `out_sclr`.
- All outputs are registered, with no combinational path from `rd_ready` to `rd_valid`.

## Configuration
- `OUT_DRAIN_OVERRUN_EN` defined:
  - adds output `overrun` (1 bit, sticky) and input `overrun_clr` (1 bit);
  - `overrun` sets on the cycle after an overrun event;
  - `overrun` clears on `overrun_clr`, and also on reset;
  - when set and clear coincide, set wins.
- Not defined: those ports are absent and dropped frames are silent.

## Structure
- Package `out_pkg` holds:
  - `NRES`;
  - store-code constants `OC_NONE`, `OC_B11`..`OC_B44` (values 0..10);
  - drain state enum `{IDLE, SEND}`.
- Sub-module `out_bank`: a parameterised NRES×DW register bank with code-addressed write, valid mask, mask clear and registered read. It is instantiated twice, once as the capture bank and once as the drain bank.

## Test plan
- Full frame: store codes 1..10 with `res_in`=0x0011·code, then `out_sclr`; `rd_ready`=1.
  - Required: words 0x0011..0x00AA appear at N+1..N+10 with `rd_idx` 1..10.
  - `rd_last` only with idx 10; no `frame_err`.
- Backpressure: same frame with `rd_ready` toggling 1,0,0,1….
  - Required: `rd_data` and `rd_idx` are stable while stalled; all ten words arrive in order, none duplicated.
- Missing slot: store every code except 6, then `out_sclr`.
  - Required: `frame_err` pulses at N+1; word with idx 6 is 0x0000.
- Overlap: second frame's `out_sclr` while the first drain is at idx 4 with `rd_ready`=0.
  - Required: the second frame is dropped; `overrun`=1 (when `OUT_DRAIN_OVERRUN_EN` is defined); the first drain completes intact.
- Back-to-back and reset:
  - Final handshake coinciding with `out_sclr`: required is the next frame's idx 1 valid on the following cycle.
  - Separately, `reset_n` low at idx 5: required is all outputs 0 immediately, and the next frame drains correctly from idx 1.

Source files
------------

// File: rtl/out_pkg.sv
// Shared constants for the result-bank drain path: store codes, frame size, drain states.
package out_pkg;

    localparam int NRES = 10;

    localparam logic [3:0] OC_NONE = 4'd0;
    localparam logic [3:0] OC_B11  = 4'd1;
    localparam logic [3:0] OC_B12  = 4'd2;
    localparam logic [3:0] OC_B13  = 4'd3;
    localparam logic [3:0] OC_B14  = 4'd4;
    localparam logic [3:0] OC_B22  = 4'd5;
    localparam logic [3:0] OC_B23  = 4'd6;
    localparam logic [3:0] OC_B24  = 4'd7;
    localparam logic [3:0] OC_B33  = 4'd8;
    localparam logic [3:0] OC_B34  = 4'd9;
    localparam logic [3:0] OC_B44  = 4'd10;

    typedef enum logic {IDLE, SEND} drn_state_e;

    // Store code c addresses slot c-1; code 0 and 11..15 never match a slot.
    function automatic logic oc_hit(input logic [3:0] code, input int slot);
        return code == 4'(slot + 1);
    endfunction

endpackage

// File: rtl/out_bank.sv
// NRES x DW result bank: code-addressed write, whole-bank load, valid mask with clear,
// and a registered read port that sees the bank's next-state contents.
module out_bank
    import out_pkg::*;
#(
    parameter int DW   = 16,
    parameter int NRES = out_pkg::NRES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [3:0]               wr_code_i,
    input  logic [DW-1:0]            wr_data_i,
    input  logic                     clr_mask_i,
    input  logic                     ld_en_i,
    input  logic [NRES-1:0][DW-1:0]  ld_data_i,
    input  logic [NRES-1:0]          ld_mask_i,
    input  logic [3:0]               rd_code_i,
    output logic [DW-1:0]            rd_data_o,
    output logic [NRES-1:0][DW-1:0]  bank_o,
    output logic [NRES-1:0]          mask_o
);

    logic [NRES-1:0][DW-1:0] mem_q, mem_d;
    logic [NRES-1:0]         mask_q, mask_d;
    logic [DW-1:0]           rd_q, rd_d;

    always_comb begin
        mem_d  = mem_q;
        mask_d = mask_q;
        rd_d   = '0;
        for (int k = 0; k < NRES; k++) begin
            if (ld_en_i) begin
                mem_d[k]  = ld_data_i[k];
                mask_d[k] = ld_mask_i[k];
            end else if (wr_en_i && oc_hit(wr_code_i, k)) begin
                mem_d[k]  = wr_data_i;
                mask_d[k] = 1'b1;
            end
        end
        // Clear beats a same-cycle write: that store travels with the outgoing frame.
        if (clr_mask_i) mask_d = '0;
        for (int k = 0; k < NRES; k++)
            if (oc_hit(rd_code_i, k)) rd_d = mem_d[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '0;
            mask_q <= '0;
            rd_q   <= '0;
        end else begin
            mem_q  <= mem_d;
            mask_q <= mask_d;
            rd_q   <= rd_d;
        end
    end

    assign rd_data_o = rd_q;
    assign bank_o    = mem_q;
    assign mask_o    = mask_q;

endmodule

// File: rtl/out_drain.sv
// Double-banked reader of the output-latch stream; drains each frame over valid/ready.
// Optional OUT_DRAIN_OVERRUN_EN adds a sticky overrun flag with its clear input.
module out_drain
    import out_pkg::*;
#(
    parameter int DW   = 16,
    parameter int NRES = out_pkg::NRES
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          out_gate,
    input  logic [3:0]    ouputcon,
    input  logic          out_sclr,
    input  logic [DW-1:0] res_in,
    output logic [DW-1:0] rd_data,
    output logic [3:0]    rd_idx,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          rd_last,
    output logic          busy,
`ifdef OUT_DRAIN_OVERRUN_EN
    input  logic          overrun_clr,
    output logic          overrun,
`endif
    output logic          frame_err
);

    logic [NRES-1:0][DW-1:0] cap_bank, ld_data;
    logic [NRES-1:0]         cap_mask, ld_mask;
    logic [NRES-1:0][DW-1:0] drn_bank_unused;
    logic [NRES-1:0]         drn_mask_unused;
    logic [DW-1:0]           cap_rd_unused;

    drn_state_e state_q;
    logic [3:0] idx_q, rd_idx_q, nxt_idx;
    logic       rd_valid_q, rd_last_q, busy_q, frame_err_q;
    logic       hs, fin, accept, send_d;

    // Same-cycle store bypasses the capture bank; unwritten slots go out as zero.
    always_comb begin
        for (int k = 0; k < NRES; k++) begin
            ld_mask[k] = cap_mask[k] | (out_gate && oc_hit(ouputcon, k));
            if (out_gate && oc_hit(ouputcon, k)) ld_data[k] = res_in;
            else if (cap_mask[k])                ld_data[k] = cap_bank[k];
            else                                 ld_data[k] = '0;
        end
    end

    assign hs     = rd_valid_q && rd_ready;
    assign fin    = hs && (idx_q == 4'(NRES));
    assign accept = out_sclr && (state_q == IDLE || fin);
    assign send_d = accept || (state_q == SEND && !fin);

    always_comb begin
        nxt_idx = idx_q;
        if (accept)  nxt_idx = 4'd1;
        else if (hs && !fin) nxt_idx = idx_q + 4'd1;
    end

    out_bank #(.DW(DW), .NRES(NRES)) u_cap (
        .clk(CLK), .rst_n(reset_n),
        .wr_en_i(out_gate), .wr_code_i(ouputcon), .wr_data_i(res_in),
        .clr_mask_i(out_sclr),
        .ld_en_i(1'b0), .ld_data_i('0), .ld_mask_i('0),
        .rd_code_i(OC_NONE), .rd_data_o(cap_rd_unused),
        .bank_o(cap_bank), .mask_o(cap_mask)
    );

    // Read address is the next index, so rd_data lines up with rd_idx each cycle.
    out_bank #(.DW(DW), .NRES(NRES)) u_drn (
        .clk(CLK), .rst_n(reset_n),
        .wr_en_i(1'b0), .wr_code_i(OC_NONE), .wr_data_i('0),
        .clr_mask_i(1'b0),
        .ld_en_i(accept), .ld_data_i(ld_data), .ld_mask_i(ld_mask),
        .rd_code_i(nxt_idx), .rd_data_o(rd_data),
        .bank_o(drn_bank_unused), .mask_o(drn_mask_unused)
    );

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idx_q       <= 4'd1;
            rd_idx_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= send_d ? SEND : IDLE;
            idx_q       <= nxt_idx;
            rd_valid_q  <= send_d;
            busy_q      <= send_d;
            rd_last_q   <= send_d && (nxt_idx == 4'(NRES));
            if (send_d) rd_idx_q <= nxt_idx;
            frame_err_q <= accept && !(&ld_mask);
        end
    end

`ifdef OUT_DRAIN_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n)                               overrun_q <= 1'b0;
        else if (out_sclr && state_q == SEND && !fin) overrun_q <= 1'b1;
        else if (overrun_clr)                       overrun_q <= 1'b0;
    end

    assign overrun = overrun_q;
`endif

    assign rd_idx    = rd_idx_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule
